// File: rtl/crypto_link_pkg.sv
// Shared definitions for the board-to-board crypto link: frame tag,
// responder state encoding and frame sizing helper.
package crypto_link_pkg;

  localparam logic [7:0] KEY_HDR_TAG = 8'h4B;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    SHIFT,
    DONE
  } resp_state_e;

  function automatic int frame_bits(input int hdr_w, input int key_w, input int e_field_w);
    return hdr_w + key_w + e_field_w;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for one async pin, with rise/fall pulses
// derived from the synchronized level.
module sync_edge_detect #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic pin_in,
  output logic lvl_out,
  output logic rise_out,
  output logic fall_out
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = STAGES'({sync_q, pin_in});
    prev_d = sync_q[STAGES-1];
  end

  // Reset to the pin's idle level so leaving reset creates no spurious edge.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign lvl_out  = sync_q[STAGES-1];
  assign rise_out = lvl_out & ~prev_q;
  assign fall_out = ~lvl_out & prev_q;

endmodule

// File: rtl/spi_key_responder.sv
// Serves {header, N, e} MSB-first on sdi in response to the peer's key
// request, shifting on the peer's synchronized SCLK falling edges.
module spi_key_responder
  import crypto_link_pkg::*;
#(
  parameter int KEY_SIZE    = 64,
  parameter int E_WIDTH     = 17,
  parameter int HEADER_SIZE = 32,
  parameter int E_FIELD     = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic [KEY_SIZE-1:0] key_n_in,
  input  logic [E_WIDTH-1:0]  key_e_in,
  input  logic                key_valid_in,
  input  logic                key_req_in,
  input  logic                spi_sel_in,
  input  logic                spi_clk_in,
  output logic                sdi_out,
  output logic                busy_out,
  output logic                done_out,
  output logic                error_out
);

  localparam int FRAME_BITS = frame_bits(HEADER_SIZE, KEY_SIZE, E_FIELD);
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);
  localparam logic [HEADER_SIZE-1:0] HEADER =
    HEADER_SIZE'({KEY_HDR_TAG, 8'(KEY_SIZE / 8), 16'(E_WIDTH)});

  logic req_lvl, req_rise, req_fall;
  logic sel_lvl, sel_rise, sel_fall;
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic unused_sync;

  sync_edge_detect #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_req (
    .clk_in(clk_in), .rst_in(rst_in), .pin_in(key_req_in),
    .lvl_out(req_lvl), .rise_out(req_rise), .fall_out(req_fall));

  sync_edge_detect #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sel (
    .clk_in(clk_in), .rst_in(rst_in), .pin_in(spi_sel_in),
    .lvl_out(sel_lvl), .rise_out(sel_rise), .fall_out(sel_fall));

  sync_edge_detect #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk_in(clk_in), .rst_in(rst_in), .pin_in(spi_clk_in),
    .lvl_out(sclk_lvl), .rise_out(sclk_rise), .fall_out(sclk_fall));

  // The peer samples on SCLK rise, so only the falling edge matters here.
  assign unused_sync = &{1'b0, sclk_lvl, sclk_rise, req_fall};

  logic [FRAME_BITS-1:0] frame;
  assign frame = {HEADER, key_n_in, E_FIELD'(key_e_in)};

  resp_state_e           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic                  sdi_q, sdi_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    sdi_d   = sdi_q;
    done_d  = 1'b0;
    error_d = 1'b0;
    case (state_q)
      IDLE: begin
        sdi_d = 1'b0;
        if (req_rise) begin
          if (key_valid_in) begin
            shreg_d = frame;
            cnt_d   = CNT_W'(FRAME_BITS);
            if (sel_fall) begin
              state_d = SHIFT;
              sdi_d   = frame[FRAME_BITS-1];
            end else begin
              state_d = ARMED;
            end
          end else begin
            error_d = 1'b1;
          end
        end
      end
      ARMED: begin
        if (sel_fall) begin
          state_d = SHIFT;
          sdi_d   = shreg_q[FRAME_BITS-1];
        end else if (!req_lvl) begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (sel_rise) begin
          error_d = 1'b1;
          sdi_d   = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (sclk_fall) begin
          shreg_d = {shreg_q[FRAME_BITS-2:0], 1'b0};
          cnt_d   = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            done_d  = 1'b1;
            sdi_d   = 1'b0;
            state_d = DONE;
          end else begin
            sdi_d = shreg_q[FRAME_BITS-2];
          end
        end
      end
      DONE: begin
        sdi_d = 1'b0;
        if (sel_lvl) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      sdi_q   <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      sdi_q   <= sdi_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign sdi_out   = sdi_q;
  assign busy_out  = (state_q != IDLE);
  assign done_out  = done_q;
  assign error_out = error_q;

endmodule

// File: doc/spi_key_responder.md
Name: spi_key_responder

Overview:
SPI-slave-side responder that serves this board's RSA public key (N, e) to the peer board. The peer's spi_controller TX side raises key_req before it encrypts to us. This block answers that request by shifting a framed {header, N, e} out on the sdi line, clocked by the peer's SPI clock. It sits between the crypto setup logic (source of N and e) and the pmoda receive pins.

Parameters:
- KEY_SIZE, 64, modulus N width in bits.
- E_WIDTH, 17, public exponent width in bits; must be ≤ E_FIELD.
- HEADER_SIZE, 32, frame header width.
- E_FIELD, 32, exponent field width in frame; e is zero-extended to this.
- SYNC_STAGES, 2, flip-flop stages on each async pin input.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset
- key_n_in  input  KEY_SIZE  modulus N
- key_e_in  input  E_WIDTH  public exponent e
- key_valid_in  input  1  crypto setup finished; key inputs stable
- key_req_in  input  1  peer key request pin (async, active-high)
- spi_sel_in  input  1  peer slave select (async, active-low)
- spi_clk_in  input  1  peer SPI clock (async, mode 0, idles low)
- sdi_out  output  1  serial key data to peer
- busy_out  output  1  high outside IDLE
- done_out  output  1  1-cycle pulse when the last frame bit has been presented
- error_out  output  1  1-cycle pulse on a refused or aborted request

Behaviour:
- Interface: one clock, clk_in; rst_in is synchronous and active-high.
- Reset values: sdi_out=0, busy_out=0, done_out=0, error_out=0, state=IDLE, bit counter=0.
- All three pins pass through SYNC_STAGES flip-flops. Edges are detected on the synchronized copies.
  - Peer SCLK must be ≤ clk_in/8.
- Frame: FRAME_BITS = HEADER_SIZE+KEY_SIZE+E_FIELD (128 by default), sent MSB-first.
  - Header = {8'h4B, 8'(KEY_SIZE/8), 16'(E_WIDTH)}.
  - Followed by N, then zero-extended e.
- States:
  - IDLE:
    - key_req rising edge with key_valid_in=1 → load shift register, counter=FRAME_BITS, go to ARMED.
    - key_req rising edge with key_valid_in=0 → error_out pulse, stay in IDLE.
  - ARMED:
    - sel falling edge → sdi_out = frame MSB on the next cycle, go to SHIFT.
    - key_req falls before sel → go to IDLE, no error.
  - SHIFT:
    - Each synchronized SCLK falling edge → shift left, counter decrements, sdi_out = next bit.
    - Rising edges are ignored; the peer samples on them.
    - Counter reaches 0 after the falling edge following the final bit's rising edge → done_out pulse, go to DONE.
  - DONE: sdi_out=0; waits for sel high → IDLE.
- Key latching: N and e are captured only on IDLE→ARMED. Changes while busy are ignored.
- Abort: sel rising edge in SHIFT with counter>0 → error_out pulse, sdi_out=0, go to IDLE.
- Extra SCLK edges in DONE: sdi_out stays 0.
- Simultaneous key_req edge and sel falling edge in IDLE: load the frame and enter SHIFT directly with the MSB presented.
- key_req rising edge while busy: ignored.
- Synchronous reset mid-frame: immediate IDLE; sdi_out=0 next cycle; no done_out or error_out.

Decomposition:
- Shared package crypto_link_pkg holds:
  - KEY_HDR_TAG = 8'h4B
  - the responder state enum (IDLE, ARMED, SHIFT, DONE)
  - frame-bit-count localparam helper
- Sub-module sync_edge_detect (parameter STAGES):
  - input: async pin
  - outputs: synchronized level, rise pulse, fall pulse
  - instantiated three times.
- Counter width is $clog2(FRAME_BITS+1).

Test Plan:
- Bench drives SCLK at clk_in/10 throughout.
- Full frame: N=64'h7ACF, e=17'h10001, key_valid=1; raise key_req, drop sel, 128 SCLK pulses → sampled bits = 128'h4B080011_00000000_00007ACF_00010001; one done_out pulse.
- Not ready: key_valid=0, raise key_req → one error_out pulse; busy_out stays 0; sdi_out stays 0 through 128 clocks.
- Abort: full-frame setup, raise sel after 40 bits → error_out pulse; busy_out=0 within SYNC_STAGES+2 cycles; a new key_req then yields a complete correct frame.
- Key change mid-frame: after 10 bits, change N to 64'h1234 → frame still carries 64'h7ACF.
- Reset mid-SHIFT: assert rst_in 1 cycle at bit 70 → sdi_out=0, busy_out=0 next cycle; no done_out or error_out.
- Withdrawn request: raise and drop key_req with sel held high → returns to IDLE, no pulses; 12 extra SCLK pulses after DONE → sdi_out stays 0.
